// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : First-word-fall-through byte FIFO between a producer and a
//               UART transmitter. The head entry is always presented on
//               rd_data while rd_valid is high. The status outputs are
//               derived only from the registered occupancy count.
//               Optional feature macro: UART_TX_FIFO_OVERFLOW_EN adds a sticky
//               overflow flag and its overflow_clr input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                     overflow,
  input  logic                     overflow_clr
`endif
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Status flags and handshake qualification, all from pre-edge registered state
  always_comb begin
    full     = (count == FULL_COUNT);
    empty    = (count == '0);
    rd_valid = !empty;
    push     = wr_en && !full;
    pop      = rd_valid && rd_ready;
    rd_data  = empty ? '0 : mem[rd_ptr];
  end

  // Storage array; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  // Sticky overflow: a push attempted while full sets it, and set beats clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo with a queue-based
//               reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             full;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             empty;
  logic [4:0]       count;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic             overflow;
  logic             overflow_clr;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .empty    (empty),
    .count    (count)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q[$];
  logic       obs_pop;
  logic [7:0] obs_data;

  function automatic logic [7:0] exp_head();
    return (model_q.size() > 0) ? model_q[0] : 8'h00;
  endfunction

  // One clock cycle: called at a negedge, returns at the following negedge.
  // Captures the DUT's pop handshake just before the edge, then advances the model.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic rr);
    bit do_push;
    bit do_pop;
    wr_en    = we;
    wr_data  = wd;
    rd_ready = rr;
    #4;
    obs_pop  = rd_valid && rd_ready;
    obs_data = rd_data;
    do_push  = we && (model_q.size() < DEPTH);
    do_pop   = rr && (model_q.size() > 0);
    @(posedge clk);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(wd);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    overflow_clr = 1'b0;
`endif
    #3;
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if (count !== 5'd0)    begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
`ifdef UART_TX_FIFO_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
  endtask

  task automatic test_single();
    cycle(1'b1, 8'h9B, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 8'h9B) begin errors++; $display("FAIL single_rd_data got %h exp 9b", rd_data); end
    checks++; if (count !== 5'd1)    begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL single_pop_empty got %b exp 1", empty); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL single_pop_rd_data got %h exp 00", rd_data); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    checks++; if (full !== 1'b1)   begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count); end
    cycle(1'b1, 8'hFF, 1'b0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_drop_count got %0d exp 16", count); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (!obs_pop || obs_data !== 8'(i)) begin
        errors++; $display("FAIL drain_order[%0d] got %h (pop %b) exp %h", i, obs_data, obs_pop, 8'(i));
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    checks++; if (obs_data !== 8'h40) begin errors++; $display("FAIL fullpp_pop_data got %h exp 40", obs_data); end
    checks++; if (count !== 5'd15)    begin errors++; $display("FAIL fullpp_count got %0d exp 15", count); end
    checks++; if (full !== 1'b0)      begin errors++; $display("FAIL fullpp_full got %b exp 0", full); end
`ifdef UART_TX_FIFO_OVERFLOW_EN
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    overflow_clr = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
`endif
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (!obs_pop || obs_data !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL fullpp_drain[%0d] got %h exp %h", i, obs_data, 8'h40 + 8'(i));
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty got %b exp 1", empty); end
  endtask

  task automatic test_stream();
    logic [7:0] sent[$];
    logic [7:0] recv[$];
    logic [7:0] cur;
    logic       rr;
    bit         acc;
    int         max_count;
    cur = 8'($urandom); rr = 1'b1; max_count = 0;
    for (int n = 0; n < 400; n++) begin
      if (sent.size() == 40 && recv.size() == 40) break;
      acc = (sent.size() < 40) && (model_q.size() < DEPTH);
      cycle(sent.size() < 40, cur, rr);
      if (acc) begin sent.push_back(cur); cur = 8'($urandom); end
      if (obs_pop) recv.push_back(obs_data);
      if (int'(count) > max_count) max_count = int'(count);
      checks++;
      if (count !== 5'(model_q.size())) begin errors++; $display("FAIL stream_count got %0d exp %0d", count, model_q.size()); end
      rr = ~rr;
    end
    checks++; if (recv.size() != 40) begin errors++; $display("FAIL stream_len got %0d exp 40", recv.size()); end
    checks++; if (max_count > DEPTH) begin errors++; $display("FAIL stream_max_count got %0d exp <=16", max_count); end
    for (int i = 0; i < 40 && i < recv.size(); i++) begin
      checks++;
      if (recv[i] !== sent[i]) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, recv[i], sent[i]); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL areset_precount got %0d exp 5", count); end
    wr_en = 1'b0; rd_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL areset_empty got %b exp 1", empty); end
    checks++; if (count !== 5'd0)    begin errors++; $display("FAIL areset_count got %0d exp 0", count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL areset_rd_data got %h exp 00", rd_data); end
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (!obs_pop || obs_data !== 8'hA5) begin errors++; $display("FAIL areset_first got %h exp a5", obs_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL areset_after_empty got %b exp 1", empty); end
  endtask

  task automatic test_push_empty_ready();
    cycle(1'b1, 8'h3C, 1'b1);
    checks++; if (obs_pop !== 1'b0)  begin errors++; $display("FAIL pe_no_pop got %b exp 0", obs_pop); end
    checks++; if (count !== 5'd1)    begin errors++; $display("FAIL pe_count got %0d exp 1", count); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL pe_rd_data got %h exp 3c", rd_data); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic       we;
    logic       rr;
    logic       exp_pop;
    logic [7:0] exp_pd;
    for (int n = 0; n < 300; n++) begin
      we = (n < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
      rr = (n < 150) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 7);
      exp_pop = rr && (model_q.size() > 0);
      exp_pd  = exp_head();
      cycle(we, 8'($urandom), rr);
      checks++;
      if (obs_pop !== exp_pop || (exp_pop && obs_data !== exp_pd)) begin
        errors++; $display("FAIL rand_pop[%0d] got %b/%h exp %b/%h", n, obs_pop, obs_data, exp_pop, exp_pd);
      end
      checks++;
      if (count !== 5'(model_q.size()) || rd_data !== exp_head() ||
          full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0) ||
          rd_valid !== (model_q.size() != 0)) begin
        errors++; $display("FAIL rand_state[%0d] got cnt %0d data %h f%b e%b v%b exp cnt %0d data %h",
                           n, count, rd_data, full, empty, rd_valid, model_q.size(), exp_head());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_stream();
    test_async_reset();
    test_push_empty_ready();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no completion exp finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, number of byte entries; power of two, 2..256.
REQ-002 SHALL provide parameter WIDTH, default 8, bits per entry.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_data  input  WIDTH  byte from producer.
REQ-006 SHALL have port wr_en  input  1  push request, qualified by !full.
REQ-007 SHALL have port full  output  1  high when count == DEPTH.
REQ-008 SHALL have port rd_data  output  WIDTH  head entry presented to uart_tx; 0 when empty.
REQ-009 SHALL have port rd_valid  output  1  equals !empty.
REQ-010 SHALL have port rd_ready  input  1  transmitter accepts head byte this cycle.
REQ-011 SHALL have port empty  output  1  high when count == 0.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 SHALL accept a push when wr_en && !full, writing wr_data at the write pointer.
REQ-014 SHALL perform a pop when rd_valid && rd_ready, advancing the read pointer.
REQ-015 SHALL operate first-word-fall-through: a byte pushed into an empty FIFO appears on rd_data with rd_valid high in the cycle after the push edge.
REQ-016 SHALL evaluate full and empty from pre-edge state; a push while full is dropped even if a pop occurs the same cycle.
REQ-017 SHALL ignore rd_ready while empty; a simultaneous push into an empty FIFO is accepted and count becomes 1.
REQ-018 SHALL leave count unchanged on a cycle with both an accepted push and an accepted pop.
REQ-019 SHALL wrap read and write pointers from DEPTH-1 to 0 with no gap or lost entry.
REQ-020 SHALL preserve byte order exactly; no duplication or reordering across wrap.
REQ-021 SHALL drive full, empty, rd_valid and count from registered state only, with no combinational path from wr_en or rd_ready.

Reset
REQ-022 SHALL, on reset low, clear both pointers and count immediately, without waiting for clk.
REQ-023 SHALL hold outputs during reset at: empty=1, full=0, rd_valid=0, rd_data=0, count=0.
REQ-024 SHALL discard all stored entries on reset asserted mid-operation; no pre-reset byte SHALL appear on rd_data afterwards.
REQ-025 SHALL accept the first push on the first rising clk edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro UART_TX_FIFO_OVERFLOW_EN defined, add ports overflow (output 1, sticky) and overflow_clr (input 1).
REQ-027 With UART_TX_FIFO_OVERFLOW_EN defined, overflow SHALL set on any cycle with wr_en && full.
REQ-028 With UART_TX_FIFO_OVERFLOW_EN defined, overflow SHALL clear on overflow_clr and on reset, and set wins when both occur in one cycle.
REQ-029 SHALL, without UART_TX_FIFO_OVERFLOW_EN, have neither port, and dropped pushes SHALL be silent.

Verification
REQ-030 Reset, then push 8'h9B in one cycle -> next cycle rd_valid=1, rd_data=8'h9B, count=1; pop -> empty=1, rd_data=0.
REQ-031 Push 16 bytes 8'h00..8'h0F with rd_ready=0 -> full=1, count=16; 17th push 8'hFF dropped; drain yields 8'h00..8'h0F in order.
REQ-032 At count=16, assert wr_en=1 and rd_ready=1 together -> pop occurs, push dropped, count=15; with macro defined, overflow=1 until overflow_clr.
REQ-033 Stream 40 bytes with continuous push and pop, rd_ready toggling every cycle -> received sequence equals sent sequence across pointer wrap, with count never exceeding 16.
REQ-034 Assert reset asynchronously between clk edges at count=5 -> empty=1 and count=0 before the next edge; the next pushed byte 8'hA5 is the first popped byte.
REQ-035 With empty FIFO, push 8'h3C while rd_ready=1 in the same cycle -> no pop; next cycle count=1, rd_data=8'h3C.
